sha256_round_sched: RTL and testbench

- Sequencer for the 5-stage pipelined SHA-256 compression-round unit.
- Accepts one 512-bit padded message block per transaction and loads the working letters a..h from the IV or the chaining digest.
- Issues rounds 0..63 to the round unit, one at a time, and manages the 16-word message-schedule ring.
- Performs the final feed-forward add and presents the 256-bit digest on a valid/ready handshake.

---
 rtl/sha256_round_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_sha256_round_sched.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_sched.sv
// ---------------------------------------------------------------------------
// sha256_round_sched
//
// Sequencer for a pipelined SHA-256 compression-round unit. It accepts one
// padded 512-bit message block and seeds the working letters a..h from the
// IV or from the stored chain digest. It then issues rounds 0..63 one at a
// time, keeping the 16-word message-schedule ring up to date. At the end it
// adds the letters back into the chain and presents the 256-bit digest on a
// valid/ready handshake.
//
// Parameters:
//   RND_LAT  round-unit latency, issue to result, in cycles (default 5)
//   TMO_CYC  watchdog limit in WAIT, in cycles (default 8)
//
// Optional feature (macro SHA256_ROUND_SCHED_TIMEOUT_EN):
//   defined   - a watchdog aborts a round that gets no result within TMO_CYC
//               cycles. It pulses o_err, zeroes the chain and returns to IDLE.
//   undefined - WAIT lasts until a result arrives; o_err is tied 0.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   i_blk_valid/o_blk_ready  block handshake (ready only in IDLE)
//   i_blk_first              1: seed from IV, 0: seed from chain digest
//   i_blk_words[511:0]       M[0] in [511:480] ... M[15] in [31:0]
//   o_dig_valid/i_dig_ready  digest handshake
//   o_digest[255:0]          H0 in [255:224] ... H7 in [31:0]
//   o_rnd_letters[7:0]       letters to round unit, index 0 = a
//   o_rnd_counter[5:0]       round index t
//   o_rnd_w[3:0]             window W[t-16], W[t-15], W[t-7], W[t-2]
//   o_rnd_w_bypass           round unit takes o_rnd_w[0] as W[t] (t < 16)
//   o_rnd_valid              one-cycle issue strobe
//   i_rnd_letters/i_rnd_w    round result: letters and the W[t] it used
//   i_rnd_valid              round result strobe (honoured only in WAIT)
//   o_busy                   controller not idle
//   o_err                    watchdog abort pulse
// ---------------------------------------------------------------------------
module sha256_round_sched #(
    parameter int RND_LAT = 5,
    parameter int TMO_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_blk_valid,
    output logic              o_blk_ready,
    input  logic              i_blk_first,
    input  logic [511:0]      i_blk_words,
    output logic              o_dig_valid,
    input  logic              i_dig_ready,
    output logic [255:0]      o_digest,
    output logic [7:0][31:0]  o_rnd_letters,
    output logic [5:0]        o_rnd_counter,
    output logic [3:0][31:0]  o_rnd_w,
    output logic              o_rnd_w_bypass,
    output logic              o_rnd_valid,
    input  logic [7:0][31:0]  i_rnd_letters,
    input  logic [31:0]       i_rnd_w,
    input  logic              i_rnd_valid,
    output logic              o_busy,
    output logic              o_err
);

    // Both parameters must describe at least one cycle.
    if (RND_LAT < 1 || TMO_CYC < 1) begin : g_param_check
        $error("sha256_round_sched: RND_LAT and TMO_CYC must be at least 1");
    end

    // IV with index 0 = a (H0).
    localparam logic [7:0][31:0] IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_FINAL,
        S_OUT
    } state_t;

    state_t            state;
    logic [5:0]        t;
    logic [7:0][31:0]  letters;
    logic [15:0][31:0] ring;
    // Holds the base H of the block in flight and becomes the chain digest
    // when FINAL writes the sum back.
    logic [7:0][31:0]  chain;
    logic [7:0][31:0]  h_sum;
    logic [3:0][31:0]  win;
    logic              bypass;
    logic              blk_ready_q;
    logic              dig_valid_q;
    logic              rnd_valid_q;
    logic              busy_q;
    logic [255:0]      digest_q;

`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TMO_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYC - 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;
`endif

    // Window selection. Ring slot (t-k) mod 16 is a 4-bit offset from t[3:0].
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves a value held and no latch is inferred.
        win    = '0;
        bypass = 1'b0;
        if (state == S_ISSUE) begin
            win[0] = ring[t[3:0]];
            if (t[5:4] == 2'b00) begin
                bypass = 1'b1;
            end else begin
                win[1] = ring[t[3:0] + 4'd1];
                win[2] = ring[t[3:0] + 4'd9];
                win[3] = ring[t[3:0] + 4'd14];
            end
        end
    end

    // Feed-forward sum, mod 2^32 per word.
    always_comb begin
        h_sum = '0;
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = chain[i] + letters[i];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            t           <= '0;
            letters     <= '0;
            // NOTE: the ring and chain are reset on purpose. A reset must
            // leave no trace of the aborted message, and a first=0 block
            // after reset chains from zero.
            ring        <= '0;
            chain       <= '0;
            digest_q    <= '0;
            blk_ready_q <= 1'b1;
            dig_valid_q <= 1'b0;
            rnd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
            wd_cnt      <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rnd_valid_q <= 1'b0;
`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (i_blk_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            ring[i] <= i_blk_words[511 - 32*i -: 32];
                        end
                        letters     <= i_blk_first ? IV : chain;
                        chain       <= i_blk_first ? IV : chain;
                        t           <= '0;
                        state       <= S_ISSUE;
                        blk_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        rnd_valid_q <= 1'b1;
                    end
                end

                S_ISSUE: begin
                    state <= S_WAIT;
`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end

                S_WAIT: begin
                    if (i_rnd_valid) begin
                        letters <= i_rnd_letters;
                        // From round 16 on, W[t] replaces W[t-16] in the same slot.
                        if (t[5:4] != 2'b00) begin
                            ring[t[3:0]] <= i_rnd_w;
                        end
                        if (t == 6'd63) begin
                            state <= S_FINAL;
                        end else begin
                            t           <= t + 6'd1;
                            state       <= S_ISSUE;
                            rnd_valid_q <= 1'b1;
                        end
                    end
`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
                    else if (wd_cnt == WD_LAST) begin
                        err_q       <= 1'b1;
                        chain       <= '0;
                        state       <= S_IDLE;
                        busy_q      <= 1'b0;
                        blk_ready_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                S_FINAL: begin
                    chain <= h_sum;
                    for (int i = 0; i < 8; i++) begin
                        digest_q[255 - 32*i -: 32] <= h_sum[i];
                    end
                    dig_valid_q <= 1'b1;
                    state       <= S_OUT;
                end

                S_OUT: begin
                    if (i_dig_ready) begin
                        dig_valid_q <= 1'b0;
                        blk_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    blk_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    dig_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_blk_ready    = blk_ready_q;
    assign o_dig_valid    = dig_valid_q;
    assign o_digest       = digest_q;
    assign o_rnd_letters  = letters;
    assign o_rnd_counter  = t;
    assign o_rnd_w        = win;
    assign o_rnd_w_bypass = bypass;
    assign o_rnd_valid    = rnd_valid_q;
    assign o_busy         = busy_q;
`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
    assign o_err          = err_q;
`else
    assign o_err          = 1'b0;
`endif

endmodule

// File: tb/tb_sha256_round_sched.sv
// ---------------------------------------------------------------------------
// tb_sha256_round_sched
//
// Bench for sha256_round_sched. A behavioural round unit with latency
// RND_LAT answers every issue strobe. Digests are compared with known SHA-256
// vectors and with a plain SHA-256 compression model that tracks the chain
// digest across blocks.
// ---------------------------------------------------------------------------
module tb_sha256_round_sched;

    localparam int RND_LAT = 5;
    localparam int TMO_CYC = 8;
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_blk_valid;
    logic              o_blk_ready;
    logic              i_blk_first;
    logic [511:0]      i_blk_words;
    logic              o_dig_valid;
    logic              i_dig_ready;
    logic [255:0]      o_digest;
    logic [7:0][31:0]  o_rnd_letters;
    logic [5:0]        o_rnd_counter;
    logic [3:0][31:0]  o_rnd_w;
    logic              o_rnd_w_bypass;
    logic              o_rnd_valid;
    logic [7:0][31:0]  i_rnd_letters;
    logic [31:0]       i_rnd_w;
    logic              i_rnd_valid;
    logic              o_busy;
    logic              o_err;

    sha256_round_sched #(.RND_LAT(RND_LAT), .TMO_CYC(TMO_CYC)) dut (
        .clk(clk), .rst(rst),
        .i_blk_valid(i_blk_valid), .o_blk_ready(o_blk_ready),
        .i_blk_first(i_blk_first), .i_blk_words(i_blk_words),
        .o_dig_valid(o_dig_valid), .i_dig_ready(i_dig_ready),
        .o_digest(o_digest),
        .o_rnd_letters(o_rnd_letters), .o_rnd_counter(o_rnd_counter),
        .o_rnd_w(o_rnd_w), .o_rnd_w_bypass(o_rnd_w_bypass),
        .o_rnd_valid(o_rnd_valid),
        .i_rnd_letters(i_rnd_letters), .i_rnd_w(i_rnd_w),
        .i_rnd_valid(i_rnd_valid),
        .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    // ---------------- SHA-256 reference ----------------
    logic [31:0] k_tab [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // One compression round on letters l (index 0 = a).
    function automatic logic [7:0][31:0] round_step(input logic [7:0][31:0] l, input int t,
                                                    input logic [31:0] w);
        logic [31:0] t1, t2;
        logic [7:0][31:0] n;
        t1 = l[7] + bsig1(l[4]) + ((l[4] & l[5]) ^ (~l[4] & l[6])) + k_tab[t] + w;
        t2 = bsig0(l[0]) + ((l[0] & l[1]) ^ (l[0] & l[2]) ^ (l[1] & l[2]));
        n[7] = l[6]; n[6] = l[5]; n[5] = l[4]; n[4] = l[3] + t1;
        n[3] = l[2]; n[2] = l[1]; n[1] = l[0]; n[0] = t1 + t2;
        return n;
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h_in, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [7:0][31:0] h, v;
        logic [255:0] r;
        for (int i = 0; i < 8; i++) h[i] = h_in[255 - 32*i -: 32];
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) w[i] = ssig1(w[i-2]) + w[i-7] + ssig0(w[i-15]) + w[i-16];
        v = h;
        for (int i = 0; i < 64; i++) v = round_step(v, i, w[i]);
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
        return r;
    endfunction

    // ---------------- behavioural round unit ----------------
    typedef struct {
        int               due;
        logic [7:0][31:0] l;
        logic [31:0]      w;
    } rres_t;

    rres_t pend[$];
    int    cyc = 0;
    int    strobes = 0;
    int    drop_rnd = -1;
    int    drop_issue_cyc = -1;

    initial begin : rnd_unit
        logic [31:0] w;
        i_rnd_valid   = 1'b0;
        i_rnd_letters = '0;
        i_rnd_w       = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            i_rnd_valid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
                i_rnd_valid   = 1'b1;
                i_rnd_letters = pend[0].l;
                i_rnd_w       = pend[0].w;
                void'(pend.pop_front());
            end
            if (o_rnd_valid) begin
                strobes++;
                if (o_rnd_w_bypass) w = o_rnd_w[0];
                else w = ssig1(o_rnd_w[3]) + o_rnd_w[2] + ssig0(o_rnd_w[1]) + o_rnd_w[0];
                if (int'(o_rnd_counter) == drop_rnd) drop_issue_cyc = cyc;
                else pend.push_back('{cyc + RND_LAT, round_step(o_rnd_letters, int'(o_rnd_counter), w), w});
            end
        end
    end

    // ---------------- checking helpers ----------------
    int total = 0;
    int bad   = 0;
    logic [255:0] model_chain = '0;
    logic [255:0] exp_dig;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_block(input logic first, input logic [511:0] blk);
        int n = 0;
        @(negedge clk);
        i_blk_valid = 1'b1;
        i_blk_first = first;
        i_blk_words = blk;
        while (!o_blk_ready && n < 2000) begin @(negedge clk); n++; end
        check("blk_ready_before_accept", 256'(o_blk_ready), 256'(1));
        @(posedge clk); #1;
        i_blk_valid = 1'b0;
        exp_dig     = sha_compress(first ? IV : model_chain, blk);
        model_chain = exp_dig;
    endtask

    // Returns the cycle number (accepting cycle = 0) of the first o_dig_valid.
    task automatic wait_digest(output int cycn);
        cycn = 1;
        while (!o_dig_valid && cycn < 3000) begin @(posedge clk); #1; cycn++; end
    endtask

    task automatic take_digest(input string name);
        i_dig_ready = 1'b1;
        @(posedge clk); #1;
        i_dig_ready = 1'b0;
        check({name, "_dig_valid_drop"}, 256'(o_dig_valid), 256'(0));
        check({name, "_digest_held"}, o_digest, exp_dig);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        pend.delete();
        model_chain = '0;
        #1;
        check("rst_blk_ready", 256'(o_blk_ready), 256'(1));
        check("rst_zero_outs",
              256'({o_dig_valid, o_rnd_counter, o_rnd_w_bypass, o_rnd_valid, o_busy, o_err}), 256'(0));
        check("rst_digest", o_digest, 256'(0));
        check("rst_letters", o_rnd_letters, 256'(0));
        check("rst_window", 256'(o_rnd_w), 256'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic         first;
        logic [511:0] blk;
        logic         known;
        logic [255:0] dig;
    } vec_t;

    vec_t vecs[4];

    initial begin : watchdog
        #2ms;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int cycn, n, err_pulses, err_cyc;
        logic [255:0] held;
        logic hold_stable, hold_ready_low;
        int s0;
        logic [511:0] rblk;
        logic rfirst;

        vecs[0] = '{1'b1, {32'h61626380, 448'h0, 32'h00000018}, 1'b1,
                    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad};
        vecs[1] = '{1'b1, {32'h80000000, 480'h0}, 1'b1,
                    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855};
        vecs[2] = '{1'b1, {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                           32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                           32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                           32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000}, 1'b0, 256'h0};
        vecs[3] = '{1'b0, {480'h0, 32'h000001c0}, 1'b1,
                    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1};

        rst = 1'b1;
        i_blk_valid = 1'b0;
        i_blk_first = 1'b0;
        i_blk_words = '0;
        i_dig_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset_pulse();

        // Known-answer vectors, including a two-block chained message.
        for (int i = 0; i < 4; i++) begin
            start_block(vecs[i].first, vecs[i].blk);
            wait_digest(cycn);
            check($sformatf("vec%0d_latency", i), 256'(cycn), 256'(64 * (RND_LAT + 1) + 2));
            check($sformatf("vec%0d_model", i), o_digest, exp_dig);
            if (vecs[i].known) check($sformatf("vec%0d_known", i), o_digest, vecs[i].dig);
            take_digest($sformatf("vec%0d", i));
        end

        // Back-pressure: digest held, next block refused, no rounds issued.
        start_block(1'b1, vecs[0].blk);
        wait_digest(cycn);
        check("hold_first_digest", o_digest, vecs[0].dig);
        @(negedge clk);
        held = o_digest;
        s0 = strobes;
        hold_stable = 1'b1;
        hold_ready_low = 1'b1;
        i_blk_valid = 1'b1;
        i_blk_first = 1'b1;
        i_blk_words = vecs[1].blk;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_digest !== held || o_dig_valid !== 1'b1) hold_stable = 1'b0;
            if (o_blk_ready !== 1'b0) hold_ready_low = 1'b0;
        end
        check("hold_digest_stable", 256'(hold_stable), 256'(1));
        check("hold_blk_ready_low", 256'(hold_ready_low), 256'(1));
        check("hold_no_strobes", 256'(strobes), 256'(s0));
        @(posedge clk); #1;
        take_digest("hold");
        check("hold_ready_after_hs", 256'(o_blk_ready), 256'(1));
        start_block(1'b1, vecs[1].blk);
        wait_digest(cycn);
        check("hold_next_digest", o_digest, vecs[1].dig);
        take_digest("hold_next");

        // Reset in the middle of round 30.
        start_block(1'b1, vecs[0].blk);
        n = 0;
        do begin @(negedge clk); n++; end
        while (!(o_rnd_valid && o_rnd_counter == 6'd30) && n < 1000);
        check("midrst_reached_r30", 256'(o_rnd_counter), 256'(30));
        reset_pulse();
        start_block(1'b1, vecs[0].blk);
        wait_digest(cycn);
        check("midrst_abc_digest", o_digest, vecs[0].dig);
        take_digest("midrst_abc");

        // Random blocks; first=0 after a reset chains from zero.
        reset_pulse();
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 16; i++) rblk[511 - 32*i -: 32] = $urandom();
            rfirst = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            start_block(rfirst, rblk);
            wait_digest(cycn);
            check($sformatf("rand%0d_latency", k), 256'(cycn), 256'(64 * (RND_LAT + 1) + 2));
            check($sformatf("rand%0d_digest", k), o_digest, exp_dig);
            take_digest($sformatf("rand%0d", k));
        end

`ifdef SHA256_ROUND_SCHED_TIMEOUT_EN
        // Watchdog: the round-40 result is never delivered.
        drop_rnd = 40;
        start_block(1'b1, vecs[0].blk);
        err_pulses = 0;
        err_cyc = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (o_err) begin
                err_pulses++;
                if (err_cyc < 0) err_cyc = cyc;
            end
            if (o_dig_valid) err_pulses += 100;
        end
        drop_rnd = -1;
        check("tmo_err_pulses", 256'(err_pulses), 256'(1));
        check("tmo_err_timing", 256'(err_cyc), 256'(drop_issue_cyc + 1 + TMO_CYC));
        check("tmo_idle", 256'({o_blk_ready, o_busy, o_dig_valid}), 256'(3'b100));
        model_chain = '0;
        start_block(1'b0, vecs[0].blk);
        wait_digest(cycn);
        check("tmo_chain_zeroed", o_digest, exp_dig);
        take_digest("tmo_after");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
